// File: rtl/mux_seq_pkg.sv
// Shared state encoding and default constants for the mux_sequencer block.
// Channel skipping (MUX_SEQ_SKIP_EN) is handled in the top, not here.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  localparam int DEF_TICKS_PER_STEP = 50000000;
  localparam int DEF_NUM_CH         = 6;
  localparam int SEL_W              = 3;

endpackage

// File: rtl/mux_sequencer_tick_prescaler.sv
// Step-interval counter: counts 0..TICKS-1 while enabled, clear has priority.
// tc_o is combinational and high only in the enabled, uncleared terminal cycle.
module tick_prescaler
  import mux_seq_pkg::*;
#(
  parameter int TICKS = DEF_TICKS_PER_STEP
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int            CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tc_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_sequencer.sv
// Timed mux-select sequencer with start/stop/hold/load control; sel, step, wrap registered.
// Define MUX_SEQ_SKIP_EN to add ch_mask_i and skip disabled channels on each step.
module mux_sequencer
  import mux_seq_pkg::*;
#(
  parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int NUM_CH         = DEF_NUM_CH
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              hold_i,
  input  logic              direction_i,
  input  logic              load_i,
  input  logic [SEL_W-1:0]  load_sel_i,
`ifdef MUX_SEQ_SKIP_EN
  input  logic [NUM_CH-1:0] ch_mask_i,
`endif
  output logic [SEL_W-1:0]  sel_o,
  output logic              step_o,
  output logic              wrap_o,
  output logic              running_o
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  seq_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic             tc;
  logic             adv_ok;
  logic             adv_wrap;
  logic [SEL_W-1:0] adv_sel;
  logic [SEL_W-1:0] load_val;

  tick_prescaler #(
    .TICKS (TICKS_PER_STEP)
  ) u_presc (
    .clk_i    (clock_i),
    .rst_i    (reset_i),
    .clear_i  (load_i || stop_i || (state_q == ST_IDLE)),
    .enable_i (state_q == ST_RUN),
    .tc_o     (tc)
  );

  // Compare in 4 bits so NUM_CH=8 does not alias to zero.
  assign load_val = ({1'b0, load_sel_i} >= 4'(NUM_CH)) ? LAST_CH : load_sel_i;

`ifdef MUX_SEQ_SKIP_EN
  int         cand;
  logic       crossed;
  logic [2:0] cidx;
  logic [7:0] mask8;

  assign mask8 = 8'(ch_mask_i);

  always_comb begin
    adv_sel  = sel_q;
    adv_wrap = 1'b0;
    adv_ok   = 1'b0;
    cand     = 0;
    crossed  = 1'b0;
    cidx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!adv_ok) begin
        if (direction_i) begin
          cand    = int'(sel_q) + i;
          crossed = (cand >= NUM_CH);
          if (crossed) cand = cand - NUM_CH;
        end else begin
          cand    = int'(sel_q) - i;
          crossed = (cand < 0);
          if (crossed) cand = cand + NUM_CH;
        end
        cidx = 3'(cand);
        if (mask8[cidx]) begin
          adv_ok   = 1'b1;
          adv_sel  = cidx;
          adv_wrap = crossed;
        end
      end
    end
  end
`else
  always_comb begin
    adv_ok   = 1'b1;
    adv_sel  = sel_q;
    adv_wrap = 1'b0;
    if (direction_i) begin
      if (sel_q == LAST_CH) begin
        adv_sel  = '0;
        adv_wrap = 1'b1;
      end else begin
        adv_sel = sel_q + SEL_W'(1);
      end
    end else begin
      if (sel_q == '0) begin
        adv_sel  = LAST_CH;
        adv_wrap = 1'b1;
      end else begin
        adv_sel = sel_q - SEL_W'(1);
      end
    end
  end
`endif

  // tc is already suppressed by load/stop through the prescaler clear.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i && !stop_i) state_d = ST_RUN;
      ST_RUN: begin
        if (stop_i)      state_d = ST_IDLE;
        else if (hold_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop_i)       state_d = ST_IDLE;
        else if (!hold_i) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_i) begin
      sel_d = load_val;
    end else if (tc && adv_ok) begin
      sel_d  = adv_sel;
      step_d = 1'b1;
      wrap_d = adv_wrap;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sel_o     = sel_q;
  assign step_o    = step_q;
  assign wrap_o    = wrap_q;
  assign running_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed table-driven bench for mux_sequencer with TICKS_PER_STEP=4, NUM_CH=6.
module tb_mux_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0, direction = 1'b1, load = 1'b0;
  logic [2:0] load_sel = 3'd0;
  logic [2:0] sel_o;
  logic       step_o, wrap_o, running_o;
`ifdef MUX_SEQ_SKIP_EN
  logic [5:0] ch_mask = 6'b111111;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_sequencer #(
    .TICKS_PER_STEP (4),
    .NUM_CH         (6)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .start_i     (start),
    .stop_i      (stop),
    .hold_i      (hold),
    .direction_i (direction),
    .load_i      (load),
    .load_sel_i  (load_sel),
`ifdef MUX_SEQ_SKIP_EN
    .ch_mask_i   (ch_mask),
`endif
    .sel_o       (sel_o),
    .step_o      (step_o),
    .wrap_o      (wrap_o),
    .running_o   (running_o)
  );

  typedef struct {
    string      name;
    logic       st, sp, h, d, ld;
    logic [2:0] ls;
    int         n;
    logic [2:0] esel;
    logic       estep, ewrap, erun;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic st, input logic sp, input logic h,
                              input logic d, input logic ld, input logic [2:0] ls, input int n,
                              input logic [2:0] es, input logic ep, input logic ew, input logic er);
    vec_t v;
    v.name = nm; v.st = st; v.sp = sp; v.h = h; v.d = d; v.ld = ld; v.ls = ls; v.n = n;
    v.esel = es; v.estep = ep; v.ewrap = ew; v.erun = er;
    return v;
  endfunction

  task automatic check(input string nm, input logic [2:0] es, input logic ep,
                       input logic ew, input logic er);
    checks++;
    if ({sel_o, step_o, wrap_o, running_o} !== {es, ep, ew, er}) begin
      errors++;
      $display("FAIL %s: got sel=%0d step=%0b wrap=%0b run=%0b, want sel=%0d step=%0b wrap=%0b run=%0b",
               nm, sel_o, step_o, wrap_o, running_o, es, ep, ew, er);
    end
  endtask

  task automatic run_vec(input vec_t v);
    start = v.st; stop = v.sp; hold = v.h; direction = v.d; load = v.ld; load_sel = v.ls;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; load = 1'b0;
    for (int k = 1; k < v.n; k++) begin
      @(posedge clk); #1;
    end
    check(v.name, v.esel, v.estep, v.ewrap, v.erun);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_async", 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    //            name           st sp h  d  ld ls n  sel step wrap run
    tbl.push_back(mk("start",     1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("cnt3",      0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 1));
    tbl.push_back(mk("step1",     0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk("pulse_end", 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk("step2",     0, 0, 0, 1, 0, 0, 3, 2, 1, 0, 1));
    tbl.push_back(mk("step3",     0, 0, 0, 1, 0, 0, 4, 3, 1, 0, 1));
    tbl.push_back(mk("step4",     0, 0, 0, 1, 0, 0, 4, 4, 1, 0, 1));
    tbl.push_back(mk("step5",     0, 0, 0, 1, 0, 0, 4, 5, 1, 0, 1));
    tbl.push_back(mk("wrap_up",   0, 0, 0, 1, 0, 0, 4, 0, 1, 1, 1));
    tbl.push_back(mk("wrap_dn",   0, 0, 0, 0, 0, 0, 4, 5, 1, 1, 1));
    tbl.push_back(mk("down4",     0, 0, 0, 0, 0, 0, 4, 4, 1, 0, 1));
    tbl.push_back(mk("down3",     0, 0, 0, 0, 0, 0, 4, 3, 1, 0, 1));
    tbl.push_back(mk("load_clamp",0, 0, 0, 0, 1, 7, 1, 5, 0, 0, 1));
    tbl.push_back(mk("load_wait", 0, 0, 0, 0, 0, 0, 3, 5, 0, 0, 1));
    tbl.push_back(mk("load_next", 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 1));
    tbl.push_back(mk("pre_term",  0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 1));
    tbl.push_back(mk("load_term", 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 1));
    tbl.push_back(mk("after_ld",  0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 1));
    tbl.push_back(mk("pre_hold",  0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1));
    tbl.push_back(mk("hold10",    0, 0, 1, 0, 0, 0,10, 1, 0, 0, 1));
    tbl.push_back(mk("unhold",    0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk("hold_step", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk("stop",      0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("idle",      0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
    tbl.push_back(mk("start_stop",1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("ss_idle",   0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
    tbl.push_back(mk("restart",   1, 0, 0, 1, 0, 0, 4, 0, 0, 0, 1));
    tbl.push_back(mk("stop_term", 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("start_hold",1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("held",      0, 0, 1, 1, 0, 0, 6, 0, 0, 0, 1));
    tbl.push_back(mk("held_rel",  0, 0, 0, 1, 0, 0, 4, 1, 1, 0, 1));
    tbl.push_back(mk("stop2",     0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk("idle_ld0",  0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("idle_ld6",  0, 0, 0, 1, 1, 6, 1, 5, 0, 0, 0));
    tbl.push_back(mk("idle_ld4",  0, 0, 0, 1, 1, 4, 1, 4, 0, 0, 0));

    do_reset();
    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous reset in the middle of a run, away from any clock edge.
    run_vec(mk("rs_start",  1, 0, 0, 1, 0, 0, 1, 4, 0, 0, 1));
    run_vec(mk("rs_load3",  0, 0, 0, 1, 1, 3, 2, 3, 0, 0, 1));
    do_reset();
    run_vec(mk("rs_idle",   0, 0, 0, 1, 0, 0, 5, 0, 0, 0, 0));
    run_vec(mk("rs_start2", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1));
    run_vec(mk("rs_cnt3",   0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 1));
    run_vec(mk("rs_step",   0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1));

`ifdef MUX_SEQ_SKIP_EN
    ch_mask = 6'b100101;
    do_reset();
    run_vec(mk("sk_start",  1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1));
    run_vec(mk("sk_to2",    0, 0, 0, 1, 0, 0, 4, 2, 1, 0, 1));
    run_vec(mk("sk_to5",    0, 0, 0, 1, 0, 0, 4, 5, 1, 0, 1));
    run_vec(mk("sk_wrap0",  0, 0, 0, 1, 0, 0, 4, 0, 1, 1, 1));
    run_vec(mk("sk_dn5",    0, 0, 0, 0, 0, 0, 4, 5, 1, 1, 1));
    run_vec(mk("sk_ld_dis", 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1));
    ch_mask = 6'b000000;
    run_vec(mk("sk_none1",  0, 0, 0, 1, 0, 0, 4, 1, 0, 0, 1));
    run_vec(mk("sk_none2",  0, 0, 0, 1, 0, 0, 4, 1, 0, 0, 1));
    ch_mask = 6'b001000;
    run_vec(mk("sk_resume", 0, 0, 0, 1, 0, 0, 4, 3, 1, 0, 1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
